// File: rtl/hand_writer.sv
// Write-side controller for the blackjack game-state RAM: appends dealt cards to the
// player/dealer hand regions, rewrites count and score after each card, and clears hands.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a card or a clear request
// WR_CARD  | write card byte to slot at old count; update count/sum/ace
// WR_COUNT | write new card count of the target hand
// WR_SCORE | write new score of the target hand
// CLR_PC   | write 0 to player count
// CLR_PS   | write 0 to player score
// CLR_DC   | write 0 to dealer count
// CLR_DS   | write 0 to dealer score
module hand_writer #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_CARDS  = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  card_valid,
   output logic                  card_ready,
   input  logic [3:0]            card_rank,
   input  logic [1:0]            card_suit,
   input  logic                  card_is_dealer,
   input  logic                  clear_hands,
   output logic [ADDR_WIDTH-1:0] addr_wr,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  write_en,
   output logic [3:0]            player_count,
   output logic [3:0]            dealer_count,
   output logic [4:0]            player_score,
   output logic [4:0]            dealer_score,
   output logic                  player_bust,
   output logic                  dealer_bust,
   output logic                  err_full,
   output logic                  err_rank,
   output logic                  busy
);

   typedef enum logic [2:0] {
      IDLE, WR_CARD, WR_COUNT, WR_SCORE, CLR_PC, CLR_PS, CLR_DC, CLR_DS
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] A_P_CARD  = ADDR_WIDTH'(8'h00);
   localparam logic [ADDR_WIDTH-1:0] A_P_COUNT = ADDR_WIDTH'(8'h0B);
   localparam logic [ADDR_WIDTH-1:0] A_D_CARD  = ADDR_WIDTH'(8'h0C);
   localparam logic [ADDR_WIDTH-1:0] A_D_COUNT = ADDR_WIDTH'(8'h17);
   localparam logic [ADDR_WIDTH-1:0] A_P_SCORE = ADDR_WIDTH'(8'h1B);
   localparam logic [ADDR_WIDTH-1:0] A_D_SCORE = ADDR_WIDTH'(8'h1C);
   localparam logic [3:0]            MAX_CNT   = 4'(MAX_CARDS);

   state_t     state, state_nxt;
   logic [3:0] lat_rank;
   logic [1:0] lat_suit;
   logic       lat_dealer;
   logic [6:0] p_sum, d_sum;
   logic       p_ace, d_ace;
   logic       clr_pend;
   logic       rank_ok, tgt_full, clr_start, accept, card_go;
   logic [6:0] card_value;

   function automatic logic [4:0] score_of(input logic [6:0] hs, input logic ace);
      logic [6:0] s;
      s = (ace && hs <= 7'd11) ? hs + 7'd10 : hs;
      return (s > 7'd31) ? 5'd31 : s[4:0];
   endfunction

   assign rank_ok    = (card_rank != 4'd0) && (card_rank <= 4'd13);
   assign tgt_full   = card_is_dealer ? (dealer_count == MAX_CNT) : (player_count == MAX_CNT);
   assign clr_start  = (state == IDLE) && (clear_hands || clr_pend);
   assign card_ready = (state == IDLE) && !clear_hands && !clr_pend;
   assign accept     = card_valid && card_ready;
   assign card_go    = accept && rank_ok && !tgt_full;
   assign card_value = (lat_rank == 4'd1)  ? 7'd1 :
                       (lat_rank >= 4'd10) ? 7'd10 : {3'b000, lat_rank};

   assign player_score = score_of(p_sum, p_ace);
   assign dealer_score = score_of(d_sum, d_ace);
   assign player_bust  = player_score > 5'd21;
   assign dealer_bust  = dealer_score > 5'd21;
   assign busy         = state != IDLE;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (clr_start)    state_nxt = CLR_PC;
            else if (card_go) state_nxt = WR_CARD;
         end
         WR_CARD:  state_nxt = WR_COUNT;
         WR_COUNT: state_nxt = WR_SCORE;
         WR_SCORE: state_nxt = IDLE;
         CLR_PC:   state_nxt = CLR_PS;
         CLR_PS:   state_nxt = CLR_DC;
         CLR_DC:   state_nxt = CLR_DS;
         CLR_DS:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // RAM port decodes from registered state and hand registers only
   always_comb begin
      write_en = 1'b0;
      addr_wr  = '0;
      data_in  = '0;
      case (state)
         WR_CARD: begin
            write_en = 1'b1;
            addr_wr  = lat_dealer ? A_D_CARD + ADDR_WIDTH'(dealer_count)
                                  : A_P_CARD + ADDR_WIDTH'(player_count);
            data_in  = DATA_WIDTH'({lat_suit, lat_rank});
         end
         WR_COUNT: begin
            write_en = 1'b1;
            addr_wr  = lat_dealer ? A_D_COUNT : A_P_COUNT;
            data_in  = DATA_WIDTH'(lat_dealer ? dealer_count : player_count);
         end
         WR_SCORE: begin
            write_en = 1'b1;
            addr_wr  = lat_dealer ? A_D_SCORE : A_P_SCORE;
            data_in  = DATA_WIDTH'(lat_dealer ? dealer_score : player_score);
         end
         CLR_PC: begin write_en = 1'b1; addr_wr = A_P_COUNT; end
         CLR_PS: begin write_en = 1'b1; addr_wr = A_P_SCORE; end
         CLR_DC: begin write_en = 1'b1; addr_wr = A_D_COUNT; end
         CLR_DS: begin write_en = 1'b1; addr_wr = A_D_SCORE; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_rank     <= '0;
         lat_suit     <= '0;
         lat_dealer   <= 1'b0;
         player_count <= '0;
         dealer_count <= '0;
         p_sum        <= '0;
         d_sum        <= '0;
         p_ace        <= 1'b0;
         d_ace        <= 1'b0;
         clr_pend     <= 1'b0;
         err_rank     <= 1'b0;
         err_full     <= 1'b0;
      end else begin
         err_rank <= 1'b0;
         err_full <= 1'b0;
         if (clear_hands && state != IDLE) clr_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (clr_start) begin
                  clr_pend     <= 1'b0;
                  player_count <= '0;
                  dealer_count <= '0;
                  p_sum        <= '0;
                  d_sum        <= '0;
                  p_ace        <= 1'b0;
                  d_ace        <= 1'b0;
               end else if (accept) begin
                  if (!rank_ok)      err_rank <= 1'b1;
                  else if (tgt_full) err_full <= 1'b1;
                  else begin
                     lat_rank   <= card_rank;
                     lat_suit   <= card_suit;
                     lat_dealer <= card_is_dealer;
                  end
               end
            end
            WR_CARD: begin
               if (lat_dealer) begin
                  dealer_count <= dealer_count + 4'd1;
                  d_sum        <= d_sum + card_value;
                  if (lat_rank == 4'd1) d_ace <= 1'b1;
               end else begin
                  player_count <= player_count + 4'd1;
                  p_sum        <= p_sum + card_value;
                  if (lat_rank == 4'd1) p_ace <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hand_writer.sv
// Self-checking bench for hand_writer: RAM writes go through a scoreboard queue fed by a
// card-level blackjack model; hand outputs and error pulses are checked after each request.
module tb_hand_writer;

   localparam int MAXC = 11;

   logic       clk = 1'b0;
   logic       rst;
   logic       card_valid, card_ready, card_is_dealer, clear_hands;
   logic [3:0] card_rank;
   logic [1:0] card_suit;
   logic [4:0] addr_wr;
   logic [7:0] data_in;
   logic       write_en;
   logic [3:0] player_count, dealer_count;
   logic [4:0] player_score, dealer_score;
   logic       player_bust, dealer_bust, err_full, err_rank, busy;

   hand_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .MAX_CARDS(MAXC)) dut (
      .clk(clk), .rst(rst),
      .card_valid(card_valid), .card_ready(card_ready),
      .card_rank(card_rank), .card_suit(card_suit), .card_is_dealer(card_is_dealer),
      .clear_hands(clear_hands),
      .addr_wr(addr_wr), .data_in(data_in), .write_en(write_en),
      .player_count(player_count), .dealer_count(dealer_count),
      .player_score(player_score), .dealer_score(dealer_score),
      .player_bust(player_bust), .dealer_bust(dealer_bust),
      .err_full(err_full), .err_rank(err_rank), .busy(busy)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   bit          mon_en = 0;
   logic [12:0] exp_q[$];

   // reference hand model: card list per hand (0 = player, 1 = dealer)
   int m_cards[2][$];

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int card_val(input int r);
      if (r == 1)  return 1;
      if (r >= 10) return 10;
      return r;
   endfunction

   // best blackjack total: one ace may count 11 if that does not bust; capped at 31
   function automatic int hand_score(input int d);
      int  total = 0;
      bit  ace = 0;
      foreach (m_cards[d][i]) begin
         total += card_val(m_cards[d][i]);
         if (m_cards[d][i] == 1) ace = 1;
      end
      if (ace && total + 10 <= 21) total += 10;
      return (total > 31) ? 31 : total;
   endfunction

   always @(negedge clk) begin
      if (mon_en && write_en) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", addr_wr, data_in);
         end else begin
            logic [12:0] e;
            e = exp_q.pop_front();
            if ({addr_wr, data_in} !== e) begin
               miscompares++;
               $display("FAIL ram_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                        addr_wr, data_in, e[12:8], e[7:0]);
            end
         end
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < 20 && !card_ready; i++) @(negedge clk);
      if (!card_ready) check("ready_timeout", card_ready, 1);
   endtask

   task automatic check_hand(input int d);
      int sc;
      sc = hand_score(d);
      if (d == 0) begin
         check("player_count", player_count, m_cards[0].size());
         check("player_score", player_score, sc);
         check("player_bust", player_bust, sc > 21);
      end else begin
         check("dealer_count", dealer_count, m_cards[1].size());
         check("dealer_score", dealer_score, sc);
         check("dealer_bust", dealer_bust, sc > 21);
      end
   endtask

   task automatic push_card(input int r, input int s, input int d);
      int n;
      n = m_cards[d].size();
      exp_q.push_back({5'((d ? 12 : 0) + n), 8'((s << 4) | r)});
      m_cards[d].push_back(r);
      exp_q.push_back({5'(d ? 8'h17 : 8'h0B), 8'(n + 1)});
      exp_q.push_back({5'(d ? 8'h1C : 8'h1B), 8'(hand_score(d))});
   endtask

   task automatic push_clear();
      exp_q.push_back({5'h0B, 8'h00});
      exp_q.push_back({5'h1B, 8'h00});
      exp_q.push_back({5'h17, 8'h00});
      exp_q.push_back({5'h1C, 8'h00});
      m_cards[0].delete();
      m_cards[1].delete();
   endtask

   task automatic send_card(input int r, input int s, input int d);
      bit bad, full;
      wait_ready();
      bad  = (r == 0) || (r > 13);
      full = m_cards[d].size() == MAXC;
      card_rank = 4'(r); card_suit = 2'(s); card_is_dealer = d[0]; card_valid = 1'b1;
      if (!bad && !full) push_card(r, s, d);
      @(posedge clk);
      @(negedge clk);
      card_valid = 1'b0;
      check("err_rank_pulse", err_rank, bad);
      check("err_full_pulse", err_full, !bad && full);
      check("busy_after_accept", busy, !bad && !full);
      if (bad || full) begin
         @(negedge clk);
         check("err_pulse_width", err_rank | err_full, 0);
      end
      wait_ready();
      check_hand(d);
   endtask

   task automatic do_clear();
      wait_ready();
      clear_hands = 1'b1;
      @(posedge clk);
      push_clear();
      @(negedge clk);
      clear_hands = 1'b0;
      check("clear_busy", busy, 1);
      wait_ready();
      check_hand(0);
      check_hand(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; card_valid = 1'b0; card_rank = '0; card_suit = '0;
      card_is_dealer = 1'b0; clear_hands = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", card_ready, 1);
      check("rst_write_en", write_en, 0);
      check("rst_addr", addr_wr, 0);
      check("rst_data", data_in, 0);
      check("rst_busy", busy, 0);
      check("rst_errs", err_rank | err_full, 0);
      check_hand(0);
      check_hand(1);
      rst = 1'b0;
      mon_en = 1'b1;

      // Ace then King for the player
      send_card(1, 0, 0);
      send_card(13, 0, 0);
      do_clear();
      // soft-ace progression, then dealer bust
      send_card(1, 0, 0);
      send_card(1, 1, 0);
      send_card(9, 2, 0);
      send_card(10, 3, 1);
      send_card(13, 0, 1);
      send_card(5, 1, 1);
      do_clear();
      // fill player hand, then overflow
      for (int i = 0; i < MAXC; i++) send_card(2, i % 4, 0);
      send_card(2, 0, 0);
      send_card(0, 0, 1);
      send_card(14, 0, 0);

      // clear requested while the card sequence is in WR_COUNT
      wait_ready();
      card_rank = 4'd5; card_suit = 2'd2; card_is_dealer = 1'b1; card_valid = 1'b1;
      push_card(5, 2, 1);
      @(posedge clk);
      @(negedge clk);
      card_valid = 1'b0;
      @(negedge clk);
      clear_hands = 1'b1;
      @(posedge clk);
      push_clear();
      @(negedge clk);
      clear_hands = 1'b0;
      @(negedge clk);
      check("pend_blocks_ready", card_ready, 0);
      check("pend_idle_busy", busy, 0);
      wait_ready();
      check_hand(0);
      check_hand(1);

      // reset during WR_CARD: only the card write happens
      wait_ready();
      card_rank = 4'd7; card_suit = 2'd1; card_is_dealer = 1'b0; card_valid = 1'b1;
      exp_q.push_back({5'h00, 8'h17});
      @(posedge clk);
      @(negedge clk);
      card_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_cards[0].delete();
      m_cards[1].delete();
      check("rst_mid_write_en", write_en, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_ready", card_ready, 1);
      check_hand(0);
      repeat (4) @(negedge clk);
      check("rst_mid_queue", exp_q.size(), 0);

      // card and clear in the same cycle: clear wins
      send_card(8, 0, 0);
      wait_ready();
      card_rank = 4'd3; card_suit = 2'd0; card_is_dealer = 1'b0; card_valid = 1'b1;
      clear_hands = 1'b1;
      @(posedge clk);
      push_clear();
      @(negedge clk);
      card_valid = 1'b0; clear_hands = 1'b0;
      wait_ready();
      check_hand(0);
      check_hand(1);

      // randomized traffic
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 11) == 0) do_clear();
         else send_card($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
      end

      repeat (6) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
